// File: rtl/palette_write_arbiter_if.sv
// Requester/palette-RAM bundle for palette_write_arbiter: request side
// (req/req_idx/req_rgb/gnt), blanking input, palette write port and busy flag.
interface palette_write_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 8,
  parameter int COLOR_W = 24
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*IDX_W-1:0]   req_idx;
  logic [N_REQ*COLOR_W-1:0] req_rgb;
  logic                     blank;
  logic [N_REQ-1:0]         gnt;
  logic                     pal_we;
  logic [IDX_W-1:0]         pal_addr;
  logic [COLOR_W-1:0]       pal_wdata;
  logic                     busy;

  modport master (
    output req, req_idx, req_rgb, blank,
    input  gnt, pal_we, pal_addr, pal_wdata, busy
  );

  modport slave (
    input  req, req_idx, req_rgb, blank,
    output gnt, pal_we, pal_addr, pal_wdata, busy
  );
endinterface

// File: rtl/palette_write_arbiter.sv
// Round-robin arbiter sharing the palette RAM write port; writes are held until blanking.
// Optional macro PALWR_PROTECT_ZERO_EN: index 0 is never written but still granted.
module palette_write_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 8,
  parameter int COLOR_W = 24
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  palette_write_arbiter_if.slave  io_bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BLK = 2'd1,
    S_WRITE    = 2'd2,
    S_ACK      = 2'd3
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_win;
  logic [IDX_W-1:0]   r_idx;
  logic [COLOR_W-1:0] r_rgb;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_pal_we;
  logic [IDX_W-1:0]   r_pal_addr;
  logic [COLOR_W-1:0] r_pal_wdata;
  logic               r_busy;

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W:0]     w_cand;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [COLOR_W-1:0] w_sel_rgb;
  logic [PTR_W-1:0]   w_rr_next;
  logic [N_REQ-1:0]   w_gnt_onehot;
  logic               w_we_ok;

  // Search from r_rr_ptr upward, wrapping modulo N_REQ; first set req bit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
      if (w_cand >= (PTR_W+1)'(N_REQ)) begin
        w_cand = w_cand - (PTR_W+1)'(N_REQ);
      end else begin
        w_cand = w_cand;
      end
      if (!w_found && io_bus.req[w_cand[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[PTR_W-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Winner's index/colour slices and the post-grant pointer.
  always_comb begin
    w_sel_idx    = io_bus.req_idx[w_win*IDX_W +: IDX_W];
    w_sel_rgb    = io_bus.req_rgb[w_win*COLOR_W +: COLOR_W];
    w_gnt_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_win;
    if (r_win == PTR_W'(N_REQ-1)) begin
      w_rr_next = '0;
    end else begin
      w_rr_next = r_win + PTR_W'(1);
    end
  end

`ifdef PALWR_PROTECT_ZERO_EN
  assign w_we_ok = (r_idx != {IDX_W{1'b0}});
`else
  assign w_we_ok = 1'b1;
`endif

  // Transaction FSM; every output is a register updated on entry to its state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_win       <= '0;
      r_idx       <= '0;
      r_rgb       <= '0;
      r_gnt       <= '0;
      r_pal_we    <= 1'b0;
      r_pal_addr  <= '0;
      r_pal_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_gnt    <= '0;
          r_pal_we <= 1'b0;
          if (w_found) begin
            r_win   <= w_win;
            r_idx   <= w_sel_idx;
            r_rgb   <= w_sel_rgb;
            r_busy  <= 1'b1;
            r_state <= S_WAIT_BLK;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT_BLK: begin
          r_gnt <= '0;
          // A withdrawn request is dropped silently and keeps its priority.
          if (!io_bus.req[r_win]) begin
            r_pal_we <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (io_bus.blank) begin
            r_pal_we    <= w_we_ok;
            r_pal_addr  <= r_idx;
            r_pal_wdata <= r_rgb;
            r_state     <= S_WRITE;
          end else begin
            r_pal_we <= 1'b0;
            r_state  <= S_WAIT_BLK;
          end
        end
        S_WRITE: begin
          r_pal_we <= 1'b0;
          r_gnt    <= w_gnt_onehot;
          r_state  <= S_ACK;
        end
        S_ACK: begin
          r_gnt    <= '0;
          r_pal_we <= 1'b0;
          r_rr_ptr <= w_rr_next;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_gnt    <= '0;
          r_pal_we <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.gnt       = r_gnt;
  assign io_bus.pal_we    = r_pal_we;
  assign io_bus.pal_addr  = r_pal_addr;
  assign io_bus.pal_wdata = r_pal_wdata;
  assign io_bus.busy      = r_busy;

endmodule
